fetch_unit: RTL

//  Instruction fetch stage directly upstream of the single-cycle core: takes the core's PC,

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_line.sv | 50 +++++
 rtl/fetch_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [XLEN-1:0] inst_t;

    localparam inst_t NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_e;

    function automatic addr_t word_align(input addr_t a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_line.sv
// One tagged fetch buffer entry: tag/data/valid register with write port,
// synchronous clear and combinational hit compare.
module fetch_line
    import fetch_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_clr,
    input  logic            i_we,
    input  logic [XLEN-1:0] i_wr_tag,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic [XLEN-1:0] i_cmp_addr,
    output logic            o_hit,
    output logic [XLEN-1:0] o_data,
    output logic [XLEN-1:0] o_tag,
    output logic            o_valid
);

    logic  valid_q, valid_d;
    addr_t tag_q, tag_d;
    inst_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (i_we) begin
            valid_d = 1'b1;
            tag_d   = i_wr_tag;
            data_d  = i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign o_hit   = valid_q && (tag_q == i_cmp_addr);
    assign o_data  = data_q;
    assign o_tag   = tag_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: tagged buffer in front of a valid/ready instruction memory.
// Optional next-line prefetch entry enabled by defining FETCH_PREFETCH_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_inst,
    output logic            o_inst_valid,
    output logic            o_fault,
    output logic            o_mem_req_valid,
    input  logic            i_mem_req_ready,
    output logic [XLEN-1:0] o_mem_req_addr,
    input  logic            i_mem_rsp_valid,
    input  logic [XLEN-1:0] i_mem_rsp_data
);

    fetch_state_e state_q, state_d;
    addr_t        addr_q, addr_d;

    logic  fault;
    addr_t pc_aligned;
    logic  rsp_we;
    logic  hit_any;
    inst_t hit_data;

    assign fault      = |i_pc[1:0];
    assign pc_aligned = word_align(i_pc);
    assign rsp_we     = (state_q == WAIT) && i_mem_rsp_valid;

`ifdef FETCH_PREFETCH_EN
    // dsel_q marks the demand entry; tgt_q is the entry the outstanding response lands in.
    logic       dsel_q, dsel_d;
    logic       tgt_q, tgt_d;
    logic [1:0] line_hit;
    logic [1:0] line_valid;
    inst_t      line_data [2];
    addr_t      line_tag  [2];
    logic       hit_sel;
    logic       other;
    addr_t      pc_next;
    logic       pf_have;

    for (genvar g = 0; g < 2; g++) begin : g_line
        fetch_line u_line (
            .i_clk      (i_clk),
            .i_clr      (i_rst),
            .i_we       (rsp_we && (tgt_q == g[0])),
            .i_wr_tag   (addr_q),
            .i_wr_data  (i_mem_rsp_data),
            .i_cmp_addr (i_pc),
            .o_hit      (line_hit[g]),
            .o_data     (line_data[g]),
            .o_tag      (line_tag[g]),
            .o_valid    (line_valid[g])
        );
    end

    assign hit_any  = |line_hit;
    assign hit_sel  = line_hit[1];
    assign hit_data = hit_sel ? line_data[1] : line_data[0];
    assign other    = ~hit_sel;
    assign pc_next  = pc_aligned + 32'd4;
    assign pf_have  = line_valid[other] && (line_tag[other] == pc_next);
`else
    logic  line_valid;
    addr_t line_tag;
    logic  unused_line;

    fetch_line u_line (
        .i_clk      (i_clk),
        .i_clr      (i_rst),
        .i_we       (rsp_we),
        .i_wr_tag   (addr_q),
        .i_wr_data  (i_mem_rsp_data),
        .i_cmp_addr (i_pc),
        .o_hit      (hit_any),
        .o_data     (hit_data),
        .o_tag      (line_tag),
        .o_valid    (line_valid)
    );

    assign unused_line = ^{line_tag, line_valid};
`endif

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        o_mem_req_valid = 1'b0;
`ifdef FETCH_PREFETCH_EN
        tgt_d  = tgt_q;
        dsel_d = (hit_any && !fault) ? hit_sel : dsel_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fault) begin
                    if (!hit_any) begin
                        addr_d  = pc_aligned;
                        state_d = REQ;
`ifdef FETCH_PREFETCH_EN
                        tgt_d   = dsel_q;
                    end else if (!pf_have) begin
                        addr_d  = pc_next;
                        tgt_d   = other;
                        state_d = REQ;
`endif
                    end
                end
            end
            REQ: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (i_mem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
`ifdef FETCH_PREFETCH_EN
            dsel_q  <= 1'b0;
            tgt_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
`ifdef FETCH_PREFETCH_EN
            dsel_q  <= dsel_d;
            tgt_q   <= tgt_d;
`endif
        end
    end

    assign o_fault        = fault;
    assign o_inst_valid   = hit_any && !fault;
    assign o_inst         = o_inst_valid ? hit_data : NOP_INST;
    assign o_mem_req_addr = addr_q;

endmodule
